seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment constants: cathode bit positions and glyph table.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int c_SEG_A  = 7;
    localparam int c_SEG_B  = 6;
    localparam int c_SEG_C  = 5;
    localparam int c_SEG_D  = 4;
    localparam int c_SEG_E  = 3;
    localparam int c_SEG_F  = 2;
    localparam int c_SEG_G  = 1;
    localparam int c_SEG_DP = 0;

    // Active-low {a,b,c,d,e,f,g}; the entry index is the hex value shown.
    localparam logic [6:0] c_SEG_PATTERN [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_HELD   = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ============================================================================
// Module   : seg7_pattern_decode
// Purpose  : Combinational active-low segment pattern to hex nibble lookup.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_valid
);

    always_comb begin
        o_nibble = 4'd0;
        o_valid  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (i_pattern == c_SEG_PATTERN[k]) begin
                o_nibble = 4'(k);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Recovers hex digits from a multiplexed 7-segment scan, frames them
//            and hands complete frames to a valid/ready consumer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [7:0]              seg,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   err_digits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam logic [7:0]            c_STABLE     = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] c_ALL_FILLED = '1;

    scan_state_t               r_state;
    logic [7:0]                r_cnt;
    logic [NUM_DIGITS+7:0]     r_prev;
    logic [4*NUM_DIGITS-1:0]   r_slot_hex;
    logic [NUM_DIGITS-1:0]     r_slot_dp;
    logic [NUM_DIGITS-1:0]     r_slot_err;
    logic [NUM_DIGITS-1:0]     r_fill;
    logic [4*NUM_DIGITS-1:0]   r_hex;
    logic [NUM_DIGITS-1:0]     r_dp;
    logic [NUM_DIGITS-1:0]     r_err;
    logic                      r_valid;
    logic                      r_overrun;

    logic [NUM_DIGITS-1:0]     w_sel;
    logic                      w_sample_ok;
    logic                      w_change;
    logic [7:0]                w_cnt_next;
    logic                      w_capture;
    logic [3:0]                w_nibble;
    logic                      w_pat_ok;
    logic [4*NUM_DIGITS-1:0]   w_next_hex;
    logic [NUM_DIGITS-1:0]     w_next_dp;
    logic [NUM_DIGITS-1:0]     w_next_err;
    logic [NUM_DIGITS-1:0]     w_fill_next;
    logic                      w_complete;
    logic                      w_fire;

    seg7_pattern_decode u_decode (
        .i_pattern (seg[c_SEG_A:c_SEG_G]),
        .o_nibble  (w_nibble),
        .o_valid   (w_pat_ok)
    );

    assign w_sel       = ~an;
    assign w_sample_ok = $onehot(w_sel);
    // A zero counter means the previous cycle was blanking, so treat it as a change.
    assign w_change    = ({an, seg} != r_prev) || (r_cnt == 8'd0);
    assign w_cnt_next  = w_change ? 8'd1 : r_cnt + 8'd1;
    assign w_capture   = w_sample_ok && (w_change || (r_state == ST_SETTLE))
                         && (w_cnt_next == c_STABLE);

    always_comb begin
        w_next_hex  = r_slot_hex;
        w_next_dp   = r_slot_dp;
        w_next_err  = r_slot_err;
        w_fill_next = r_fill;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_capture && w_sel[k]) begin
                w_next_hex[4*k +: 4] = w_nibble;
                w_next_dp[k]         = ~seg[c_SEG_DP];
                w_next_err[k]        = ~w_pat_ok;
                w_fill_next[k]       = 1'b1;
            end
        end
    end

    assign w_complete = w_capture && (w_fill_next == c_ALL_FILLED);
    assign w_fire     = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_SETTLE;
            r_cnt      <= 8'd0;
            r_prev     <= '0;
            r_slot_hex <= '0;
            r_slot_dp  <= '0;
            r_slot_err <= '0;
            r_fill     <= '0;
            r_hex      <= '0;
            r_dp       <= '0;
            r_err      <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_prev <= {an, seg};
            if (!w_sample_ok) begin
                r_cnt   <= 8'd0;
                r_state <= ST_SETTLE;
            end else begin
                if (w_change || (r_state == ST_SETTLE)) begin
                    r_cnt <= w_cnt_next;
                end
                if (w_capture) begin
                    r_state <= ST_HELD;
                end else if (w_change) begin
                    r_state <= ST_SETTLE;
                end
            end

            r_slot_hex <= w_next_hex;
            r_slot_dp  <= w_next_dp;
            r_slot_err <= w_next_err;
            r_fill     <= w_complete ? '0 : w_fill_next;

            // A frame may replace the published one only if that one is gone or leaving now.
            if (w_complete && (!r_valid || w_fire)) begin
                r_hex   <= w_next_hex;
                r_dp    <= w_next_dp;
                r_err   <= w_next_err;
                r_valid <= 1'b1;
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign hex_out    = r_hex;
    assign dp_out     = r_dp;
    assign err_digits = r_err;
    assign out_valid  = r_valid;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Purpose  : Directed scoreboard bench for seg7_scan_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_decoder;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        out_ready;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  err_digits;
    logic        out_valid;
    logic        overrun;

    frame_t exp_q[$];
    frame_t held;
    logic   held_ok = 1'b0;
    int     n_pass = 0;
    int     n_total = 0;
    int     valid_cycles = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an),
        .seg        (seg),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .err_digits (err_digits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    task automatic show(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame4(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3);
        show(4'b1110, s0, 6);
        show(4'b1101, s1, 6);
        show(4'b1011, s2, 6);
        show(4'b0111, s3, 6);
    endtask

    task automatic check_reset_state();
        check("rst_hex", 32'(hex_out), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_err", 32'(err_digits), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
    endtask

    // Scoreboard monitor: pops one expected frame per accepted handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            valid_cycles++;
            if (held_ok) check("stable_while_valid", 32'({hex_out, dp_out, err_digits}), 32'(held));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_frame: got %0h expected none",
                             {hex_out, dp_out, err_digits});
                end else begin
                    check("frame", 32'({hex_out, dp_out, err_digits}), 32'(exp_q.pop_front()));
                end
                held_ok = 1'b0;
            end else begin
                held    = {hex_out, dp_out, err_digits};
                held_ok = 1'b1;
            end
        end else begin
            held_ok = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        an        = 4'hF;
        seg       = 8'hFF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        // Digits 1,2,3,4 with dots off; one-cycle valid pulse with ready high.
        valid_cycles = 0;
        exp_q.push_back('{hex: 16'h4321, dp: 4'h0, err: 4'h0});
        frame4(8'h9F, 8'h25, 8'h0D, 8'h99);
        show(4'hF, 8'hFF, 3);
        check("valid_pulse_len", 32'(valid_cycles), 32'd1);

        // Each digit shown only three cycles: nothing may be captured.
        valid_cycles = 0;
        show(4'b1110, 8'h49, 3);
        show(4'b1101, 8'h41, 3);
        show(4'b1011, 8'h1F, 3);
        show(4'b0111, 8'h19, 3);
        show(4'hF, 8'hFF, 4);
        check("short_hold_no_frame", 32'(valid_cycles), 32'd0);

        // 8 with dot, 0 without dot, unknown glyph, 0 with dot.
        exp_q.push_back('{hex: 16'h0008, dp: 4'b1001, err: 4'b0100});
        frame4(8'h00, 8'h03, 8'hFF, 8'h02);
        show(4'hF, 8'hFF, 3);
        check("err_slot_hex", 32'(hex_out), 32'h0008);
        check("err_slot_bits", 32'(err_digits), 32'b0100);
        check("dp_bits", 32'(dp_out), 32'b1001);

        // Completion coincides with acceptance of the held frame.
        out_ready = 1'b0;
        exp_q.push_back('{hex: 16'h10FE, dp: 4'h0, err: 4'h0});
        frame4(8'h61, 8'h71, 8'h03, 8'h9F);
        exp_q.push_back('{hex: 16'h5432, dp: 4'h0, err: 4'h0});
        show(4'b1110, 8'h25, 6);
        show(4'b1101, 8'h0D, 6);
        show(4'b1011, 8'h99, 6);
        show(4'b0111, 8'h49, 3);
        out_ready = 1'b1;
        show(4'b0111, 8'h49, 3);
        show(4'hF, 8'hFF, 3);
        check("no_overrun_on_handoff", 32'(overrun), 32'h0);
        check("handoff_frames_seen", 32'(exp_q.size()), 32'd0);

        // Two frames with ready low: the second is dropped.
        out_ready = 1'b0;
        exp_q.push_back('{hex: 16'h9765, dp: 4'h0, err: 4'h0});
        frame4(8'h49, 8'h41, 8'h1F, 8'h19);
        check("overrun_after_first", 32'(overrun), 32'h0);
        frame4(8'h11, 8'hC1, 8'h63, 8'h85);
        check("overrun_after_second", 32'(overrun), 32'h1);
        check("first_frame_kept", 32'(hex_out), 32'h9765);
        out_ready = 1'b1;
        show(4'hF, 8'hFF, 3);
        check("valid_dropped", 32'(out_valid), 32'h0);
        check("overrun_sticky", 32'(overrun), 32'h1);
        check("overrun_frames_seen", 32'(exp_q.size()), 32'd0);

        // Partial frame, multi-low blanking, then reset.
        show(4'b1110, 8'h9F, 6);
        show(4'b1101, 8'h25, 6);
        show(4'b1100, 8'h25, 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        valid_cycles = 0;
        show(4'b1101, 8'h1F, 6);
        show(4'b1011, 8'h00, 6);
        show(4'b0111, 8'h19, 6);
        check("partial_discarded", 32'(valid_cycles), 32'd0);
        exp_q.push_back('{hex: 16'h987A, dp: 4'b0100, err: 4'h0});
        show(4'b1110, 8'h11, 6);
        show(4'hF, 8'hFF, 3);
        check("post_reset_frames_seen", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
